psum_drain_14: RTL

- Collects partial-sum results leaving the top row of the 12x14 PE grid and returns them to the controller or global buffer.
- On a capture strobe it snapshots all 14 column psums into one of two holding banks.
- It then serializes the snapshot as a tagged word stream with valid/ready handshake, one column per beat.
- Double buffering lets the grid launch the next pass while the previous result drains.

---
 rtl/psum_drain_14.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/psum_drain_14.sv
`default_nettype none
// ============================================================================
//  Module   : psum_drain_14
//  Purpose  : Captures the 14 column partial sums leaving the top row of the
//             PE grid into one of two holding banks, then serializes the
//             snapshot one column per beat on a valid/ready stream. Two banks
//             let the grid start its next pass while the previous one drains.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             psum_ins[]        - grid column outputs, valid with capture
//             capture           - one-cycle snapshot strobe
//             cols_active       - columns to emit (0 or >NUM_COLS = all)
//             out_data/out_col  - serialized psum word and its column tag
//             out_valid/ready   - stream handshake
//             out_last          - final beat of the snapshot
//             busy              - a bank is FULL or DRAINING
//             overflow          - sticky, a capture was dropped
//  Options  : PSUM_DRAIN_RELU_EN - when defined, negative psums (sign bit set)
//             are stored as zero at bank-write time.
//  Revision : 1.0 - initial release
// ============================================================================
module psum_drain_14 #(
    parameter int NUM_COLS = 14,
    parameter int PSUM_W   = 32,
    parameter int COL_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PSUM_W-1:0] psum_ins [0:NUM_COLS-1],
    input  logic              capture,
    input  logic [COL_W-1:0]  cols_active,
    output logic [PSUM_W-1:0] out_data,
    output logic [COL_W-1:0]  out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overflow
);

    localparam logic [1:0]       c_BANK_EMPTY    = 2'd0;
    localparam logic [1:0]       c_BANK_FULL     = 2'd1;
    localparam logic [1:0]       c_BANK_DRAINING = 2'd2;
    localparam logic [COL_W-1:0] c_NUM_COLS      = COL_W'(NUM_COLS);
    localparam logic [COL_W-1:0] c_ONE           = COL_W'(1);

    typedef enum logic [0:0] {
        c_IDLE  = 1'b0,
        c_DRAIN = 1'b1
    } drain_state_t;

    drain_state_t      r_state;
    logic [1:0][1:0]   r_bank_st;
    logic [COL_W-1:0]  r_bank_cnt [0:1];
    logic [PSUM_W-1:0] r_bank_data [0:1][0:NUM_COLS-1];
    logic              r_cur;     // bank currently being drained
    logic              r_newest;  // bank written by the most recent capture
    logic [COL_W-1:0]  r_ptr;

    logic [PSUM_W-1:0] w_wr_data [0:NUM_COLS-1];
    logic [COL_W-1:0]  w_eff_cnt;
    logic [COL_W-1:0]  w_ptr_inc;
    logic              w_hs;
    logic              w_last_hs;
    logic              w_other;
    logic              w_other_full;
    logic              w_any_full;
    logic              w_pick;
    logic              w_start;
    logic              w_switch;
    logic              w_cap_ok;
    logic              w_cap_bank;
    logic [1:0][1:0]   w_st_nxt;
    logic              w_busy_nxt;

    // Clamp happens on the way into the bank so the drain path is identical
    // in both builds.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
`ifdef PSUM_DRAIN_RELU_EN
        assign w_wr_data[gi] = psum_ins[gi][PSUM_W-1] ? '0 : psum_ins[gi];
`else
        assign w_wr_data[gi] = psum_ins[gi];
`endif
    end

    assign w_eff_cnt = ((cols_active == '0) || (cols_active > c_NUM_COLS))
                       ? c_NUM_COLS : cols_active;
    assign w_ptr_inc = r_ptr + c_ONE;

    always_comb begin
        w_hs         = out_valid && out_ready;
        w_last_hs    = w_hs && out_last;
        w_other      = ~r_cur;
        w_other_full = (r_bank_st[w_other] == c_BANK_FULL);
        w_any_full   = (r_bank_st[0] == c_BANK_FULL) || (r_bank_st[1] == c_BANK_FULL);

        // Oldest FULL bank: with both FULL the one not written last is older.
        if ((r_bank_st[0] == c_BANK_FULL) && (r_bank_st[1] == c_BANK_FULL)) begin
            w_pick = ~r_newest;
        end else begin
            w_pick = (r_bank_st[1] == c_BANK_FULL);
        end

        w_start  = (r_state == c_IDLE) && w_any_full;
        w_switch = w_last_hs && w_other_full;

        // An EMPTY bank is preferred; otherwise the bank finishing its last
        // beat at this very edge can take the new snapshot.
        w_cap_ok   = 1'b0;
        w_cap_bank = 1'b0;
        if (capture) begin
            if (r_bank_st[0] == c_BANK_EMPTY) begin
                w_cap_ok   = 1'b1;
                w_cap_bank = 1'b0;
            end else if (r_bank_st[1] == c_BANK_EMPTY) begin
                w_cap_ok   = 1'b1;
                w_cap_bank = 1'b1;
            end else if (w_last_hs) begin
                w_cap_ok   = 1'b1;
                w_cap_bank = r_cur;
            end
        end

        w_st_nxt = r_bank_st;
        if (w_last_hs) w_st_nxt[r_cur]      = c_BANK_EMPTY;
        if (w_start)   w_st_nxt[w_pick]     = c_BANK_DRAINING;
        if (w_switch)  w_st_nxt[w_other]    = c_BANK_DRAINING;
        if (w_cap_ok)  w_st_nxt[w_cap_bank] = c_BANK_FULL;

        w_busy_nxt = (w_st_nxt[0] != c_BANK_EMPTY) || (w_st_nxt[1] != c_BANK_EMPTY);
    end

    // Bank payload needs no reset: bank state alone says whether it is live.
    always_ff @(posedge clk) begin
        if (w_cap_ok) begin
            r_bank_data[w_cap_bank] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_bank_st     <= {c_BANK_EMPTY, c_BANK_EMPTY};
            r_bank_cnt[0] <= '0;
            r_bank_cnt[1] <= '0;
            r_cur         <= 1'b0;
            r_newest      <= 1'b0;
            r_ptr         <= '0;
            out_data      <= '0;
            out_col       <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            r_bank_st <= w_st_nxt;
            busy      <= w_busy_nxt;
            overflow  <= overflow | (capture & ~w_cap_ok);

            if (w_cap_ok) begin
                r_bank_cnt[w_cap_bank] <= w_eff_cnt;
                r_newest               <= w_cap_bank;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_state   <= c_DRAIN;
                        r_cur     <= w_pick;
                        r_ptr     <= '0;
                        out_valid <= 1'b1;
                        out_data  <= r_bank_data[w_pick][0];
                        out_col   <= '0;
                        out_last  <= (r_bank_cnt[w_pick] == c_ONE);
                    end
                end
                c_DRAIN: begin
                    if (w_hs) begin
                        if (out_last) begin
                            if (w_switch) begin
                                // Back-to-back hand-over, no bubble cycle.
                                r_cur    <= w_other;
                                r_ptr    <= '0;
                                out_data <= r_bank_data[w_other][0];
                                out_col  <= '0;
                                out_last <= (r_bank_cnt[w_other] == c_ONE);
                            end else begin
                                r_state   <= c_IDLE;
                                r_ptr     <= '0;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            r_ptr    <= w_ptr_inc;
                            out_data <= r_bank_data[r_cur][w_ptr_inc];
                            out_col  <= w_ptr_inc;
                            out_last <= (w_ptr_inc == (r_bank_cnt[r_cur] - c_ONE));
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
